// File: rtl/fifo_flow_flags_pkg.sv
// Shared definitions for the flow-control FIFO: default widths (also used
// by the flow-control FSM bench) and the occupancy flag bundle.
package fifo_flow_flags_pkg;

    localparam int FIFO_DATA_WIDTH = 6;
    localparam int FIFO_ADDR_WIDTH = 3;

    // Occupancy flags, in the order the flow-control FSM consumes them.
    typedef struct packed {
        logic full;
        logic almost_full;
        logic almost_empty;
        logic empty;
    } fifo_flags_t;

    // Decode occupancy against the programmable band. A threshold of 0 for
    // almost_full, or >= depth for almost_empty, naturally pins that flag high.
    function automatic fifo_flags_t decode_flags(
        input int unsigned cnt,
        input int unsigned af,
        input int unsigned ae,
        input int unsigned depth
    );
        fifo_flags_t f;
        f.full         = (cnt == depth);
        f.almost_full  = (cnt >= af);
        f.almost_empty = (cnt <= ae);
        f.empty        = (cnt == 0);
        return f;
    endfunction

endpackage

// File: rtl/fifo_flow_flags_mem.sv
// Storage array for the FIFO: one synchronous write port and one synchronous
// read port. The array itself is never reset; only the read register is.
import fifo_flow_flags_pkg::*;

module fifo_mem #(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port: capture data on an accepted push.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered; holds its value when no read is performed.
    // A write to the same address on the same edge returns the old word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_flow_flags.sv
// Synchronous FIFO with programmable almost-full/almost-empty band, sticky
// overflow/underflow errors and a registered read port. Full and empty come
// from the occupancy count, never from a pointer compare.
//
// Handshake: a push is accepted when the FIFO is not full, or when a pop is
// accepted on the same edge; a pop is accepted only when the FIFO is not
// empty. Both decisions use the registered count, so flags never depend
// combinationally on push/pop. Popped data shows on data_out, qualified by
// valid_out, for the cycle after the pop edge.
import fifo_flow_flags_pkg::*;

module fifo_flow_flags #(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic [ADDR_WIDTH:0]   umbral_af,
    input  logic [ADDR_WIDTH:0]   umbral_ae,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  empty,
    output logic                  error_overflow,
    output logic                  error_underflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_valid;
    logic                  r_err_ovf;
    logic                  r_err_unf;

    logic                  w_push_ok;
    logic                  w_pop_ok;
    fifo_flags_t           w_flags;

    // Flag decode from the count register and the live thresholds only.
    always_comb begin
        w_flags = decode_flags(32'(r_count), 32'(umbral_af), 32'(umbral_ae), DEPTH);
    end

    // Accept logic: full FIFO still takes a push if a pop frees a slot.
    always_comb begin
        w_pop_ok  = pop & ~w_flags.empty;
        w_push_ok = push & (~w_flags.full | pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // valid_out marks the cycle after an accepted pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_pop_ok;
        end
    end

    // Sticky error bits; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (push & ~w_push_ok) begin
                r_err_ovf <= 1'b1;
            end
            if (pop & w_flags.empty) begin
                r_err_unf <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_re    (w_pop_ok),
        .i_raddr (r_rd_ptr),
        .o_rdata (data_out)
    );

    assign valid_out       = r_valid;
    assign full            = w_flags.full;
    assign almost_full     = w_flags.almost_full;
    assign almost_empty    = w_flags.almost_empty;
    assign empty           = w_flags.empty;
    assign error_overflow  = r_err_ovf;
    assign error_underflow = r_err_unf;
    assign count           = r_count;

endmodule

// File: tb/tb_fifo_flow_flags.sv
// Directed bench for fifo_flow_flags: a vector table for fill/overflow/drain
// and threshold behaviour, plus hand-written multi-cycle corner sequences.
module tb_fifo_flow_flags;

  localparam int DW = 6;
  localparam int AW = 3;

  logic          clk;
  logic          reset;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   umbral_af;
  logic [AW:0]   umbral_ae;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic          empty;
  logic          error_overflow;
  logic          error_underflow;
  logic [AW:0]   count;

  int n_cmp;
  int n_fail;

  logic [DW-1:0] exp_q[$];

  fifo_flow_flags dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .data_in         (data_in),
    .pop             (pop),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .umbral_af       (umbral_af),
    .umbral_ae       (umbral_ae),
    .full            (full),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .empty           (empty),
    .error_overflow  (error_overflow),
    .error_underflow (error_underflow),
    .count           (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic [AW:0]   af;
    logic [AW:0]   ae;
    logic [AW:0]   e_count;
    logic [3:0]    e_flags;   // {full, almost_full, almost_empty, empty}
    logic          e_valid;
    logic [DW-1:0] e_dout;
    logic          e_ovf;
    logic          e_unf;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // drive one cycle of stimulus, return #1 after the active edge
  task automatic cycle(input logic p, input logic q, input logic [DW-1:0] d);
    @(negedge clk);
    push = p;
    pop = q;
    data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
  endtask

  // cycle plus a queue model used for the wrap sequence
  task automatic model_cycle(input logic p, input logic q, input logic [DW-1:0] d);
    logic          pop_ok;
    logic          push_ok;
    logic [DW-1:0] e;
    pop_ok = q && (exp_q.size() > 0);
    push_ok = p && ((exp_q.size() < 8) || q);
    e = '0;
    if (pop_ok) e = exp_q.pop_front();
    if (push_ok) exp_q.push_back(d);
    cycle(p, q, d);
    chk("wrap_valid", 32'(valid_out), 32'(pop_ok));
    if (pop_ok) chk("wrap_data", 32'(data_out), 32'(e));
    chk("wrap_count", 32'(count), 32'(exp_q.size()));
  endtask

  initial begin
    logic [DW-1:0] drain_a[8];
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    data_in = '0;
    umbral_af = 4'd6;
    umbral_ae = 4'd2;

    //           push pop din    af ae  cnt flags   v  dout   ovf unf
    vecs[0]  = '{1'b0, 1'b0, 6'h00, 6, 2, 0, 4'b0011, 0, 6'h00, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 6'h01, 6, 2, 1, 4'b0010, 0, 6'h00, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 6'h02, 6, 2, 2, 4'b0010, 0, 6'h00, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 6'h03, 6, 2, 3, 4'b0000, 0, 6'h00, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 6'h04, 6, 2, 4, 4'b0000, 0, 6'h00, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 6'h05, 6, 2, 5, 4'b0000, 0, 6'h00, 0, 0};
    vecs[6]  = '{1'b1, 1'b0, 6'h06, 6, 2, 6, 4'b0100, 0, 6'h00, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 6'h07, 6, 2, 7, 4'b0100, 0, 6'h00, 0, 0};
    vecs[8]  = '{1'b1, 1'b0, 6'h08, 6, 2, 8, 4'b1100, 0, 6'h00, 0, 0};
    vecs[9]  = '{1'b1, 1'b0, 6'h3F, 6, 2, 8, 4'b1100, 0, 6'h00, 1, 0};
    vecs[10] = '{1'b0, 1'b0, 6'h00, 6, 2, 8, 4'b1100, 0, 6'h00, 1, 0};
    vecs[11] = '{1'b0, 1'b1, 6'h00, 6, 2, 7, 4'b0100, 1, 6'h01, 1, 0};
    vecs[12] = '{1'b0, 1'b1, 6'h00, 6, 2, 6, 4'b0100, 1, 6'h02, 1, 0};
    vecs[13] = '{1'b0, 1'b1, 6'h00, 6, 2, 5, 4'b0000, 1, 6'h03, 1, 0};
    vecs[14] = '{1'b0, 1'b1, 6'h00, 6, 2, 4, 4'b0000, 1, 6'h04, 1, 0};
    vecs[15] = '{1'b0, 1'b1, 6'h00, 6, 2, 3, 4'b0000, 1, 6'h05, 1, 0};
    vecs[16] = '{1'b0, 1'b1, 6'h00, 6, 2, 2, 4'b0010, 1, 6'h06, 1, 0};
    vecs[17] = '{1'b0, 1'b1, 6'h00, 6, 2, 1, 4'b0010, 1, 6'h07, 1, 0};
    vecs[18] = '{1'b0, 1'b1, 6'h00, 6, 2, 0, 4'b0011, 1, 6'h08, 1, 0};
    vecs[19] = '{1'b0, 1'b0, 6'h00, 6, 2, 0, 4'b0011, 0, 6'h08, 1, 0};
    vecs[20] = '{1'b0, 1'b0, 6'h00, 0, 8, 0, 4'b0111, 0, 6'h08, 1, 0};
    vecs[21] = '{1'b0, 1'b0, 6'h00, 6, 2, 0, 4'b0011, 0, 6'h08, 1, 0};

    // reset value check while reset is held
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_dout", 32'(data_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // table: fill, overflow, drain, threshold overrides
    for (int i = 0; i < 22; i++) begin
      umbral_af = vecs[i].af;
      umbral_ae = vecs[i].ae;
      cycle(vecs[i].push, vecs[i].pop, vecs[i].din);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_flags", i), 32'({full, almost_full, almost_empty, empty}),
          32'(vecs[i].e_flags));
      chk($sformatf("v%0d_valid", i), 32'(valid_out), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_dout", i), 32'(data_out), 32'(vecs[i].e_dout));
      chk($sformatf("v%0d_ovf", i), 32'(error_overflow), 32'(vecs[i].e_ovf));
      chk($sformatf("v%0d_unf", i), 32'(error_underflow), 32'(vecs[i].e_unf));
    end

    // push+pop on a full FIFO
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 6'(i));
    chk("pp_fill_count", 32'(count), 32'd8);
    cycle(1'b1, 1'b1, 6'h2A);
    chk("pp_count", 32'(count), 32'd8);
    chk("pp_valid", 32'(valid_out), 32'd1);
    chk("pp_dout", 32'(data_out), 32'h01);
    chk("pp_ovf", 32'(error_overflow), 32'd0);
    drain_a = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h2A};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 6'h00);
      chk($sformatf("pp_drain%0d", i), 32'(data_out), 32'(drain_a[i]));
    end
    chk("pp_empty", 32'(empty), 32'd1);

    // pop on empty with simultaneous push
    do_reset();
    cycle(1'b1, 1'b1, 6'h15);
    chk("unf_err", 32'(error_underflow), 32'd1);
    chk("unf_valid", 32'(valid_out), 32'd0);
    chk("unf_count", 32'(count), 32'd1);
    cycle(1'b0, 1'b1, 6'h00);
    chk("unf_pop_valid", 32'(valid_out), 32'd1);
    chk("unf_pop_data", 32'(data_out), 32'h15);
    chk("unf_sticky", 32'(error_underflow), 32'd1);

    // pointer wrap, then reset while count is 5
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 12; i++) model_cycle(1'b1, (i % 2) == 1, 6'(6'h20 + i));
    model_cycle(1'b0, 1'b1, 6'h00);
    chk("wrap_count5", 32'(count), 32'd5);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_valid", 32'(valid_out), 32'd0);
    chk("mid_rst_errs", 32'({error_overflow, error_underflow}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1'b0, 6'h33);
    chk("post_rst_count", 32'(count), 32'd1);
    cycle(1'b0, 1'b1, 6'h00);
    chk("post_rst_data", 32'(data_out), 32'h33);
    chk("post_rst_unf", 32'(error_underflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
